// File: rtl/uart_tx_queue_pkg.sv
// Shared constants and types for the UART transmit byte queue.
// Holds the drain-state encodings, byte width and default sizing.
package uart_tx_queue_pkg;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned DEF_DEPTH        = 8;
    localparam int unsigned DEF_BUSY_TIMEOUT = 15;

    // Drain FSM encodings kept as plain constants for legacy compatibility
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer push port, queue status and UART_TX handshake for uart_tx_queue.
// Optional drop_count status appears when UART_TX_QUEUE_DROP_COUNT_EN is defined.
interface uart_tx_queue_if
    import uart_tx_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic          push_valid;
    byte_t         push_data;
    logic          push_ready;
    logic          full;
    logic          empty;
    logic [ADDR_W:0] level;
    logic          overflow;
    logic          uart_start;
    byte_t         uart_data;
    logic          uart_busy;
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
    logic [7:0]    drop_count;
`endif

    // Environment side: producer plus the UART_TX busy flag
    modport master (
        output push_valid, push_data, uart_busy,
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
        input  drop_count,
`endif
        input  push_ready, full, empty, level, overflow, uart_start, uart_data
    );

    modport slave (
        input  push_valid, push_data, uart_busy,
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
        output drop_count,
`endif
        output push_ready, full, empty, level, overflow, uart_start, uart_data
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage for the transmit queue: registered write, combinational read.
// Contents are not reset; validity is tracked by the owner's pointers.
module sync_fifo_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue from the CPU control FSM to UART_TX with an in-order drain FSM.
// Define UART_TX_QUEUE_DROP_COUNT_EN to add a saturating count of dropped pushes.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_queue_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned TO_W   = $clog2(BUSY_TIMEOUT + 1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, empty_q, ready_q;
    logic              overflow_q, overflow_d;
    logic [1:0]        state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              start_q, start_d;
    byte_t             data_q, data_d;
    byte_t             rd_data;
    logic              push_acc;
    logic              drop;
    logic              pop;

    // full is a flop, so a push seen while full is dropped even if a pop frees a slot
    assign push_acc = bus.push_valid && !full_q;
    assign drop     = bus.push_valid && full_q;

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (BYTE_W)
    ) u_mem (
        .clock     (clock),
        .wr_en_i   (push_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.push_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    // Pointer, occupancy and sticky overflow update
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Drain FSM: one start pulse per popped byte, abandon after BUSY_TIMEOUT idle cycles
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        start_d  = 1'b0;
        data_d   = data_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop      = 1'b1;
                    data_d   = rd_data;
                    start_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (bus.uart_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!bus.uart_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            to_cnt_q   <= '0;
            start_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_W'(DEPTH));
            empty_q    <= (count_d == '0);
            ready_q    <= (count_d != CNT_W'(DEPTH));
            overflow_q <= overflow_d;
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            start_q    <= start_d;
            data_q     <= data_d;
        end
    end

`ifdef UART_TX_QUEUE_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_count = drop_cnt_q;
`endif

    assign bus.push_ready = ready_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.level      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.uart_start = start_q;
    assign bus.uart_data  = data_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: directed pushes feed an expected-byte queue,
// a monitor checks every start pulse against it; a small UART model drives busy.
module tb_uart_tx_queue;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    uart_tx_queue_if #(.DEPTH(8)) bus ();

    uart_tx_queue dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    int  busy_delay = 1;
    int  busy_hold  = 5;
    bit  never_busy = 1'b0;
    int  dly_cnt    = 0;
    int  hold_cnt   = 0;
    logic start_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // UART_TX model: busy rises busy_delay cycles after a start and stays high busy_hold cycles
    initial begin
        bus.uart_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                bus.uart_busy = 1'b0;
                dly_cnt  = 0;
                hold_cnt = 0;
            end else begin
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) bus.uart_busy = 1'b0;
                end else if (dly_cnt > 0) begin
                    dly_cnt--;
                    if (dly_cnt == 0) begin
                        bus.uart_busy = 1'b1;
                        hold_cnt = busy_hold;
                    end
                end
                if (bus.uart_start && !never_busy) dly_cnt = busy_delay;
            end
        end
    end

    // Monitor: every start pulse must be a single cycle and carry the next expected byte
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                start_prev = 1'b0;
            end else begin
                if (bus.uart_start) begin
                    check("start_single_cycle", 32'(start_prev), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_start: got data 0x%0h, expected no start (t=%0t)", bus.uart_data, $time);
                    end else begin
                        check("uart_data_order", 32'(bus.uart_data), 32'(exp_q.pop_front()));
                    end
                end
                start_prev = bus.uart_start;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000 ns");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] d, input bit accepted);
        bus.push_valid = 1'b1;
        bus.push_data  = d;
        if (accepted) exp_q.push_back(d);
        @(negedge clock);
        bus.push_valid = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!bus.uart_start && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!bus.uart_start) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_start: no start pulse within %0d cycles, expected one", budget);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clock);
            n++;
            if (exp_q.size() == 0 && !bus.uart_busy && bus.empty && !bus.uart_start) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d bytes pending after %0d cycles, expected 0", exp_q.size(), budget);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_empty"},      32'(bus.empty),      32'd1);
        check({tag, "_full"},       32'(bus.full),       32'd0);
        check({tag, "_push_ready"}, 32'(bus.push_ready), 32'd1);
        check({tag, "_level"},      32'(bus.level),      32'd0);
        check({tag, "_overflow"},   32'(bus.overflow),   32'd0);
        check({tag, "_uart_start"}, 32'(bus.uart_start), 32'd0);
        check({tag, "_uart_data"},  32'(bus.uart_data),  32'h00);
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
        check({tag, "_drop_count"}, 32'(bus.drop_count), 32'd0);
`endif
    endtask

    initial begin
        int gap;
        reset          = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_data  = 8'h00;
        repeat (3) @(negedge clock);
        check_reset_values("por");
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single byte: push in cycle N, non-empty in N+1, start during N+2
        busy_delay = 1;
        busy_hold  = 100;
        push(8'hA5, 1'b1);
        check("single_empty_n1", 32'(bus.empty), 32'd0);
        check("single_level_n1", 32'(bus.level), 32'd1);
        @(negedge clock);
        check("single_start_n2", 32'(bus.uart_start), 32'd1);
        check("single_empty_n2", 32'(bus.empty),      32'd1);
        @(negedge clock);
        check("single_start_n3", 32'(bus.uart_start), 32'd0);
        @(negedge clock);
        busy_hold = 5;
        @(negedge clock);

        // Burst fill while the A5 frame holds busy: nothing drains, queue reaches full
        for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
        check("burst_full",       32'(bus.full),       32'd1);
        check("burst_level",      32'(bus.level),      32'd8);
        check("burst_push_ready", 32'(bus.push_ready), 32'd0);
        drain(600);
        check("burst_no_overflow", 32'(bus.overflow), 32'd0);

        // Overflow: 9 pushes (first pops at once) fill the queue, next 2 are dropped
        busy_hold = 60;
        for (int i = 0; i < 9; i++) push(8'hB0 + 8'(i), 1'b1);
        push(8'hE0, 1'b0);
        push(8'hE1, 1'b0);
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        check("ovf_full",  32'(bus.full),     32'd1);
        check("ovf_level", 32'(bus.level),    32'd8);
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
        check("ovf_drop_count", 32'(bus.drop_count), 32'd2);
`endif
        busy_hold = 5;
        drain(800);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Simultaneous push and pop: push lands in the IDLE cycle after busy falls
        busy_hold = 10;
        push(8'hC0, 1'b1);
        wait_start(10);
        push(8'hC1, 1'b1);
        push(8'hC2, 1'b1);
        push(8'hC3, 1'b1);
        repeat (9) @(negedge clock);
        check("pp_level_before", 32'(bus.level), 32'd3);
        push(8'hC4, 1'b1);
        check("pp_level_after", 32'(bus.level),      32'd3);
        check("pp_start",       32'(bus.uart_start), 32'd1);
        drain(400);

        // Busy timeout: 15 cycles in WAIT_BUSY, then the next byte gets its own start
        never_busy = 1'b1;
        push(8'hD0, 1'b1);
        push(8'hD1, 1'b1);
        wait_start(10);
        gap = 0;
        @(negedge clock);
        gap = 1;
        while (!bus.uart_start && gap < 40) begin
            @(negedge clock);
            gap++;
        end
        check("timeout_gap", 32'(gap), 32'd16);
        drain(100);
        repeat (20) @(negedge clock);
        never_busy = 1'b0;

        // Reset mid-frame with four bytes queued
        busy_hold = 50;
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b1);
        check("rst_level_before", 32'(bus.level), 32'd4);
        #2 reset = 1'b1;
        #1 check_reset_values("async");
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("post_rst_empty", 32'(bus.empty), 32'd1);
        busy_hold = 5;
        push(8'hF0, 1'b1);
        drain(200);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
